// File: rtl/simple_bfm_rsp_pkg.sv
// Shared types and default sizing for the simple_bfm responder.
// The handshake state is a single bit, and ack is the registered image of that bit.
package simple_bfm_rsp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

endpackage

// File: rtl/simple_bfm_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is read combinationally from storage.
// Push is honoured when full only if a pop happens in the same cycle.
module simple_bfm_rsp_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage is data only; stale contents are hidden by level after a reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/simple_bfm_rsp.sv
// Responder for simple_bfm: acknowledges each req pulse once and buffers its payload
// into a FWFT FIFO for a downstream consumer. It also counts accepted requests.
module simple_bfm_rsp
  import simple_bfm_rsp_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [DATA_W-1:0]      data,
  output logic                   ack,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            xfer_count
);

  state_t      state;
  logic [15:0] cnt_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic        pop;
  logic        accept;

  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts when the consumer frees a slot in the same cycle.
  assign accept     = (state == IDLE) & req & (~fifo_full | pop);
  assign xfer_count = cnt_q;

  simple_bfm_rsp_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (data),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  // ACK is held for the rest of the req high period, so each pulse pushes once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ack   <= 1'b0;
      cnt_q <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        state <= ACK;
        ack   <= 1'b1;
        cnt_q <= cnt_q + 16'd1;
      end
    end else begin
      if (!req) begin
        state <= IDLE;
        ack   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/simple_bfm_rsp.md
SIMPLE_BFM_RSP -- requirements
Module: simple_bfm_rsp

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the captured data width.
REQ-003 Port clk SHALL be an input, 1 bit wide: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-005 Port req SHALL be an input, 1 bit wide: request from simple_bfm.
REQ-006 Port data SHALL be an input, DATA_W bits wide: payload from simple_bfm, valid while req=1.
REQ-007 Port ack SHALL be an output, 1 bit wide: acknowledge to simple_bfm, driven directly from a register.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: FIFO head is valid.
REQ-009 Port out_data SHALL be an output, DATA_W bits wide: FIFO head payload.
REQ-010 Port out_ready SHALL be an input, 1 bit wide: consumer accepts the head.
REQ-011 Port level SHALL be an output, $clog2(DEPTH)+1 bits wide: current FIFO occupancy.
REQ-012 Port xfer_count SHALL be an output, 16 bits wide: accepted request count.

Function
REQ-013 The handshake FSM SHALL have exactly two states, IDLE and ACK, and ack SHALL equal (state==ACK).
REQ-014 An accept SHALL occur in a cycle where state=IDLE, req=1, and either the FIFO is not full or a pop occurs in the same cycle.
REQ-015 On an accept, data SHALL be pushed into the FIFO and state SHALL go to ACK, so ack=1 exactly one cycle after the accept cycle.
REQ-016 In state ACK, state SHALL hold while req=1 and SHALL return to IDLE in the first cycle req=0, so ack falls one cycle after req falls.
REQ-017 With a never-full FIFO, ack SHALL reproduce req delayed by one cycle, preserving simple_bfm timing.
REQ-018 In state IDLE with req=1 and the FIFO full with no pop, ack SHALL stay 0 (backpressure) and the request SHALL be accepted in the first cycle space exists.
REQ-019 A request SHALL be accepted exactly once per req high period, with no duplicate push while in ACK.
REQ-020 A pop SHALL occur when out_valid=1 and out_ready=1, and out_data SHALL be the oldest entry (FIFO order).
REQ-021 out_valid SHALL equal (level!=0) with zero-latency first-word-fall-through: a pushed word SHALL be visible on the cycle after the push.
REQ-022 A simultaneous push and pop SHALL leave level unchanged, including when the FIFO is full or when level=1.
REQ-023 level SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-024 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-025 xfer_count SHALL increment by 1 on each accept and wrap from 0xFFFF to 0x0000.
REQ-026 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally.

Reset
REQ-027 While rst=1 the module SHALL set: state=IDLE, ack=0, pointers=0, level=0, out_valid=0, xfer_count=0.
REQ-028 FIFO storage SHALL NOT be reset, and out_data SHALL be don't-care while out_valid=0.
REQ-029 A reset mid-handshake (state=ACK) SHALL force ack=0 on the next cycle.
REQ-030 A req still high after reset release SHALL be treated as a new request and accepted.
REQ-031 Buffered data SHALL be discarded on reset.

Structure
REQ-032 Package simple_bfm_rsp_pkg SHALL hold the FSM state enum (IDLE, ACK) and the default DATA_W and DEPTH constants.
REQ-033 Storage SHALL be in one sub-module, simple_bfm_rsp_fifo, a synchronous FWFT FIFO with push, pop, full, empty and level.
REQ-034 The handshake FSM and xfer_count SHALL be in the top level.

Verification
REQ-035 Reset then single transfer: req=1, data=0xA5 at cycle 0 -> ack=1 at cycle 1; out_valid=1 and out_data=0xA5 at cycle 1; xfer_count=1.
REQ-036 Back-to-back transfers 0x01..0x04 with out_ready=1 -> ack follows req delayed by 1 cycle; consumer receives 0x01,0x02,0x03,0x04 in order.
REQ-037 Full backpressure: out_ready=0, 5 requests with DEPTH=4 -> level=4 and the 5th request's ack held 0; one pop -> 5th accepted next cycle; level=4.
REQ-038 Simultaneous push and pop at full and at level=1 -> level unchanged; order preserved.
REQ-039 Reset asserted in state ACK with level=3 -> next cycle ack=0, level=0, out_valid=0; req held high is re-accepted after release.
REQ-040 Counter wrap: preload via 65536 accepts -> xfer_count=0x0000 after accept 65536, 0x0001 after the next.
